// File: rtl/spi_cs_timing_calc.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cs_timing_calc
//  Description : Works out the SPI driver's n_cs high time from the SPI clock
//                frequency. The result covers both the device update period
//                and the device's minimum n_cs high time, and a runtime
//                extra-cycle margin is added on top. The output saturates
//                when the result does not fit. Any input that changes while
//                calc is held sets a sticky lock violation.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cs_timing_calc #(
    parameter int unsigned T_UPDATE_NS     = 830,
    parameter int unsigned T_CS_HIGH_NS    = 30,
    parameter int unsigned CMD_BITS        = 24,
    parameter int unsigned MIN_HIGH_CYCLES = 4,
    parameter int unsigned OUT_WIDTH       = 5,
    parameter int unsigned MULT_BITS       = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          spi_clk_freq_hz,
    input  logic [7:0]           extra_cycles,
    input  logic                 calc,
    output logic [OUT_WIDTH-1:0] n_cs_high_time,
    output logic                 saturated,
    output logic                 done,
    output logic                 lock_viol
);

    // Times converted to 2^-30 s fixed-point per Hz and rounded up, so that
    // freq * K >> 30 rounded up gives a cycle count that is never too short.
    localparam logic [63:0] C_K_UPD_FULL  =
        (64'(T_UPDATE_NS)  * 64'd1073741824 + 64'd999999999) / 64'd1000000000;
    localparam logic [63:0] C_K_HIGH_FULL =
        (64'(T_CS_HIGH_NS) * 64'd1073741824 + 64'd999999999) / 64'd1000000000;

    // The bit counter runs 0..MULT_BITS. Its last value is the finish cycle.
    // The constants are padded to the counter range so that every counter
    // value indexes a defined bit.
    localparam int unsigned          C_CNT_W      = $clog2(MULT_BITS + 1);
    localparam int unsigned          C_PAD_W      = 1 << C_CNT_W;
    localparam logic [C_CNT_W-1:0]   C_CNT_LAST   = C_CNT_W'(MULT_BITS);
    localparam logic [C_PAD_W-1:0]   C_K_UPD      = C_K_UPD_FULL[C_PAD_W-1:0];
    localparam logic [C_PAD_W-1:0]   C_K_HIGH     = C_K_HIGH_FULL[C_PAD_W-1:0];
    localparam logic [31:0]          C_CMD        = 32'(CMD_BITS);
    localparam logic [31:0]          C_MIN_HIGH   = 32'(MIN_HIGH_CYCLES);
    localparam logic [32:0]          C_SAT_LIMIT  = 33'd1 << OUT_WIDTH;
    localparam logic [63:0]          C_RND        = 64'h0000_0000_3FFF_FFFF;

    // The shift-add multiplier only walks MULT_BITS bits of each constant.
    if (C_K_UPD_FULL >= (64'd1 << MULT_BITS)) begin : g_k_upd_too_wide
        $error("spi_cs_timing_calc: K_UPD does not fit in MULT_BITS");
    end
    if (C_K_HIGH_FULL >= (64'd1 << MULT_BITS)) begin : g_k_high_too_wide
        $error("spi_cs_timing_calc: K_HIGH does not fit in MULT_BITS");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_UPD  = 3'd1,
        S_MUL_HIGH = 3'd2,
        S_COMBINE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [31:0]          r_freq,   w_freq_nxt;
    logic [7:0]           r_extra,  w_extra_nxt;
    logic [63:0]          r_acc,    w_acc_nxt;
    logic [C_CNT_W-1:0]   r_bit,    w_bit_nxt;
    logic [31:0]          r_c_upd,  w_c_upd_nxt;
    logic [31:0]          r_c_high, w_c_high_nxt;
    logic [32:0]          r_total,  w_total_nxt;
    logic [OUT_WIDTH-1:0] w_high_time_nxt;
    logic                 w_sat_nxt, w_done_nxt, w_lock_nxt;

    logic                 w_k_bit;
    logic [63:0]          w_addend;
    logic [31:0]          w_r;
    logic [31:0]          w_c_upd;
    logic [31:0]          w_c_high;
    logic [31:0]          w_c_max;
    logic                 w_inputs_changed;

    // Datapath terms shared by both multiply phases and by the final combine.
    always_comb begin
        w_k_bit          = (r_state == S_MUL_UPD) ? C_K_UPD[r_bit] : C_K_HIGH[r_bit];
        w_addend         = {32'b0, r_freq} << r_bit;
        w_r              = 32'((r_acc + C_RND) >> 30);
        w_c_upd          = (w_r > C_CMD) ? (w_r - C_CMD) : 32'd0;
        w_c_high         = (w_r > C_MIN_HIGH) ? w_r : C_MIN_HIGH;
        w_c_max          = (r_c_upd > r_c_high) ? r_c_upd : r_c_high;
        w_inputs_changed = (spi_clk_freq_hz != r_freq) || (extra_cycles != r_extra);
    end

    // Next-state logic and next values for every register.
    always_comb begin
        w_state_nxt     = r_state;
        w_freq_nxt      = r_freq;
        w_extra_nxt     = r_extra;
        w_acc_nxt       = r_acc;
        w_bit_nxt       = r_bit;
        w_c_upd_nxt     = r_c_upd;
        w_c_high_nxt    = r_c_high;
        w_total_nxt     = r_total;
        w_high_time_nxt = n_cs_high_time;
        w_sat_nxt       = saturated;
        w_done_nxt      = done;
        w_lock_nxt      = lock_viol;

        if (r_state == S_IDLE) begin
            w_done_nxt = 1'b0;
            if (!calc) begin
                w_lock_nxt = 1'b0;
            end else if (!lock_viol) begin
                w_freq_nxt  = spi_clk_freq_hz;
                w_extra_nxt = extra_cycles;
                w_acc_nxt   = 64'd0;
                w_bit_nxt   = '0;
                w_state_nxt = S_MUL_UPD;
            end
        end else if (w_inputs_changed) begin
            // An input change wins over a simultaneous calc fall.
            w_lock_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
        end else if (!calc) begin
            w_done_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_MUL_UPD, S_MUL_HIGH: begin
                    if (r_bit != C_CNT_LAST) begin
                        if (w_k_bit) begin
                            w_acc_nxt = r_acc + w_addend;
                        end
                        w_bit_nxt = r_bit + C_CNT_W'(1);
                    end else begin
                        w_acc_nxt = 64'd0;
                        w_bit_nxt = '0;
                        if (r_state == S_MUL_UPD) begin
                            w_c_upd_nxt = w_c_upd;
                            w_state_nxt = S_MUL_HIGH;
                        end else begin
                            w_c_high_nxt = w_c_high;
                            w_state_nxt  = S_COMBINE;
                        end
                    end
                end
                S_COMBINE: begin
                    w_total_nxt = {1'b0, w_c_max} + {25'd0, r_extra};
                    w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (r_total > C_SAT_LIMIT) begin
                        w_high_time_nxt = '1;
                        w_sat_nxt       = 1'b1;
                    end else begin
                        w_high_time_nxt = OUT_WIDTH'(r_total - 33'd1);
                        w_sat_nxt       = 1'b0;
                    end
                    w_done_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. Reset clears everything, including the result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_freq         <= 32'd0;
            r_extra        <= 8'd0;
            r_acc          <= 64'd0;
            r_bit          <= '0;
            r_c_upd        <= 32'd0;
            r_c_high       <= 32'd0;
            r_total        <= 33'd0;
            n_cs_high_time <= '0;
            saturated      <= 1'b0;
            done           <= 1'b0;
            lock_viol      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_freq         <= w_freq_nxt;
            r_extra        <= w_extra_nxt;
            r_acc          <= w_acc_nxt;
            r_bit          <= w_bit_nxt;
            r_c_upd        <= w_c_upd_nxt;
            r_c_high       <= w_c_high_nxt;
            r_total        <= w_total_nxt;
            n_cs_high_time <= w_high_time_nxt;
            saturated      <= w_sat_nxt;
            done           <= w_done_nxt;
            lock_viol      <= w_lock_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cs_timing_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_cs_timing_calc
//  Description : Directed bench for spi_cs_timing_calc. The stimulus pushes
//                hand-computed results into a scoreboard queue, and a monitor
//                compares each result when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cs_timing_calc;

    localparam int unsigned C_LATENCY = 27;

    logic        clk;
    logic        resetn;
    logic [31:0] spi_clk_freq_hz;
    logic [7:0]  extra_cycles;
    logic        calc;
    logic [4:0]  n_cs_high_time;
    logic        saturated;
    logic        done;
    logic        lock_viol;

    typedef struct {
        logic [4:0] val;
        logic       sat;
        int         edge_n;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   edge_cnt  = 0;
    logic prev_done = 1'b0;

    spi_cs_timing_calc dut (
        .clk             (clk),
        .resetn          (resetn),
        .spi_clk_freq_hz (spi_clk_freq_hz),
        .extra_cycles    (extra_cycles),
        .calc            (calc),
        .n_cs_high_time  (n_cs_high_time),
        .saturated       (saturated),
        .done            (done),
        .lock_viol       (lock_viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges are numbered. The edge that latches a request is edge 1 of that request.
    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: on every rising edge of done, pop and compare the expected result.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: done rose with no pending request (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_value", 64'(n_cs_high_time), 64'(mon_e.val));
                chk("result_saturated", 64'(saturated), 64'(mon_e.sat));
                chk("result_latency_edge", 64'(edge_cnt), 64'(mon_e.edge_n));
            end
        end
        prev_done = done;
    end

    // One full request. The expected result goes to the scoreboard, then the
    // task either releases calc normally or resets while done is high.
    task automatic run(input logic [31:0] f, input logic [7:0] x,
                       input logic [4:0] ev, input logic es, input bit rst_in_done);
        exp_t e;
        spi_clk_freq_hz = f;
        extra_cycles    = x;
        calc            = 1'b1;
        e.val    = ev;
        e.sat    = es;
        e.edge_n = edge_cnt + C_LATENCY;
        sb_q.push_back(e);
        for (int i = 0; i < 40 && !done; i++) tick(1);
        chk("done_timeout", 64'(done), 64'd1);
        chk("lock_viol_clean_run", 64'(lock_viol), 64'd0);
        if (rst_in_done) begin
            resetn = 1'b0;
            calc   = 1'b0;
            tick(1);
            chk("rst_done_value", 64'(n_cs_high_time), 64'd0);
            chk("rst_done_saturated", 64'(saturated), 64'd0);
            chk("rst_done_done", 64'(done), 64'd0);
            resetn = 1'b1;
            tick(1);
        end else begin
            tick(2);
            chk("done_hold", 64'(done), 64'd1);
            calc = 1'b0;
            tick(1);
            chk("done_fall", 64'(done), 64'd0);
            chk("retain_value", 64'(n_cs_high_time), 64'(ev));
            chk("retain_saturated", 64'(saturated), 64'(es));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        resetn          = 1'b0;
        calc            = 1'b0;
        spi_clk_freq_hz = 32'd0;
        extra_cycles    = 8'd0;
        tick(3);
        chk("reset_value", 64'(n_cs_high_time), 64'd0);
        chk("reset_saturated", 64'(saturated), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_lock_viol", 64'(lock_viol), 64'd0);
        resetn = 1'b1;
        tick(1);

        // R_upd=42 -> C_upd=18. C_high=max(2,4)=4. T=18.
        run(32'd50_000_000, 8'd0, 5'd17, 1'b0, 1'b0);
        // 10 MHz: R_upd=9 -> C_upd=0. T=4. freq 0 gives the same result.
        run(32'd10_000_000, 8'd0, 5'd3, 1'b0, 1'b0);
        run(32'd0,          8'd0, 5'd3, 1'b0, 1'b0);
        // Saturation boundary: T=32 fits. T=33 and the maximum frequency do not.
        run(32'd50_000_000, 8'd14, 5'd31, 1'b0, 1'b0);
        run(32'd50_000_000, 8'd15, 5'd31, 1'b1, 1'b0);
        run(32'hFFFF_FFFF,  8'd0,  5'd31, 1'b1, 1'b0);

        // Lock violation: the frequency changes mid-calculation.
        spi_clk_freq_hz = 32'd50_000_000;
        extra_cycles    = 8'd0;
        calc            = 1'b1;
        tick(15);
        spi_clk_freq_hz = 32'd40_000_000;
        tick(1);
        chk("viol_lock_viol", 64'(lock_viol), 64'd1);
        chk("viol_done", 64'(done), 64'd0);
        chk("viol_keeps_value", 64'(n_cs_high_time), 64'd31);
        chk("viol_keeps_saturated", 64'(saturated), 64'd1);
        tick(10);
        chk("viol_no_restart_lock", 64'(lock_viol), 64'd1);
        chk("viol_no_restart_done", 64'(done), 64'd0);
        calc = 1'b0;
        tick(1);
        chk("viol_cleared", 64'(lock_viol), 64'd0);
        // 40 MHz: R_upd=34 -> C_upd=10.
        run(32'd40_000_000, 8'd0, 5'd9, 1'b0, 1'b0);

        // calc drops during MUL_UPD, then a full restart.
        spi_clk_freq_hz = 32'd50_000_000;
        calc            = 1'b1;
        tick(5);
        calc = 1'b0;
        tick(1);
        chk("drop_done", 64'(done), 64'd0);
        chk("drop_lock_viol", 64'(lock_viol), 64'd0);
        run(32'd50_000_000, 8'd0, 5'd17, 1'b0, 1'b0);

        // Reset during COMBINE: after 25 edges the latched request sits in COMBINE.
        calc = 1'b1;
        tick(25);
        chk("combine_no_done_yet", 64'(done), 64'd0);
        resetn = 1'b0;
        calc   = 1'b0;
        tick(1);
        chk("rst_combine_value", 64'(n_cs_high_time), 64'd0);
        chk("rst_combine_saturated", 64'(saturated), 64'd0);
        chk("rst_combine_done", 64'(done), 64'd0);
        chk("rst_combine_lock_viol", 64'(lock_viol), 64'd0);
        resetn = 1'b1;
        tick(1);

        // Reset during DONE, followed by a normal run.
        run(32'd50_000_000, 8'd0, 5'd17, 1'b0, 1'b1);
        run(32'd50_000_000, 8'd0, 5'd17, 1'b0, 1'b0);

        tick(3);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
